mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: MEM_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on posedge.
REQ-002 SHALL have: resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: EX_to_MEM_BUS  in  76  {pc[31:0], gr_we, dest[4:0], alu_result[31:0], load_op[3:0], rfrom_mem, mem_req}.
REQ-004 SHALL have: EX_to_MEM_valid  in  1  upstream bus valid.
REQ-005 SHALL have: MEM_allowin  out  1  stage can accept a new instruction.
REQ-006 SHALL have: data_sram_data_ok  in  1  load data returned this cycle.
REQ-007 SHALL have: data_sram_rdata  in  32  returned word.
REQ-008 SHALL have: MEM_to_WB_BUS  out  107  {pc, gr_we, dest, mem_result, alu_result, load_op, rfrom_mem}.
REQ-009 SHALL have: MEM_to_WB_valid  out  1; WB_allowin  in  1.
REQ-010 SHALL have: MEM_RF_BUS  out  38  {dest masked by gr_we&MEM_valid, rfrom_mem, final_result}.

Function
REQ-011 SHALL hold MEM_valid; MEM_allowin = !MEM_valid || (MEM_ready_go && WB_allowin).
REQ-012 SHALL load MEM_valid <= EX_to_MEM_valid whenever MEM_allowin; latch bus only when EX_to_MEM_valid && MEM_allowin.
REQ-013 SHALL implement FSM IDLE/WAIT/DONE: IDLE->WAIT on accept with mem_req=1; IDLE stays for mem_req=0.
REQ-014 SHALL in WAIT: data_ok && WB_allowin -> IDLE (or WAIT if a new mem_req instr accepted same cycle); data_ok && !WB_allowin -> DONE.
REQ-015 SHALL in DONE: WB_allowin -> IDLE/WAIT per newly accepted instr; else remain.
REQ-016 SHALL capture data_sram_rdata into a 32-bit buffer on data_ok in WAIT; ignore data_ok in IDLE/DONE.
REQ-017 SHALL set MEM_ready_go = !mem_req || state==DONE || (state==WAIT && data_ok).
REQ-018 SHALL use raw word = data_ok in WAIT ? data_sram_rdata : buffer (zero latency on same-cycle data_ok).
REQ-019 SHALL select lane by alu_result[1:0]; load_op[1:0]: 00 byte, 01 half (offset[1] picks half), 10 word; load_op[2]=1 zero-extend else sign-extend; load_op[3] ignored; 11 treated as word.
REQ-020 SHALL set MEM_to_WB_valid = MEM_valid && MEM_ready_go.
REQ-021 SHALL set final_result = rfrom_mem ? mem_result : alu_result.
REQ-022 SHALL, when MEM_valid=0, output MEM_RF_BUS dest field 5'b0.

Reset
REQ-023 SHALL on resetn=0 clear MEM_valid, latched bus (all 76 bits), buffer, state=IDLE at next posedge.
REQ-024 SHALL after reset drive MEM_to_WB_valid=0, MEM_allowin=1, MEM_to_WB_BUS=0, MEM_RF_BUS=0.
REQ-025 SHALL treat reset mid-WAIT/DONE as abort; a stale data_ok the cycle after reset is ignored (state IDLE).

Configuration
REQ-026 SHALL compile MEM_RF_BUS forwarding logic only under `MEM_FWD_EN`; undefined -> MEM_RF_BUS tied to 38'b0, port retained.
REQ-027 SHALL with MEM_FWD_EN and rfrom_mem=1 && state!=DONE && !data_ok, drive the rfrom_mem bit 1 so the decoder stalls (result not yet valid).

Verification
REQ-028 Non-load: alu_result=0x1234, mem_req=0, WB_allowin=1 -> MEM_to_WB_valid next cycle, final 0x1234, FSM stays IDLE.
REQ-029 ld.b offset 3, rdata 0x80FF_0000, data_ok 2 cycles after accept -> MEM_to_WB_valid only on data_ok cycle, mem_result 0xFFFF_FF80.
REQ-030 ld.hu offset 2, rdata 0xBEEF_1234, data_ok while WB_allowin=0 for 3 cycles -> state DONE, MEM_allowin=0, mem_result 0x0000_BEEF held until release.
REQ-031 Back-to-back: load completes with WB_allowin=1 while EX_to_MEM_valid=1 with mem_req=1 -> new instr latched same edge, state WAIT, no bubble.
REQ-032 Reset asserted in WAIT, data_ok pulsed next cycle -> MEM_to_WB_valid stays 0, buffer 0, state IDLE.
REQ-033 Build with/without MEM_FWD_EN: ld.w dest=5 waiting -> MEM_RF_BUS={5,1,x} with; 38'b0 without.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with load data wait FSM, lane extract and optional RF forwarding bus
//   clk, resetn (sync, active-low)
//   EX_to_MEM_BUS[75:0], EX_to_MEM_valid -> MEM_allowin
//   data_sram_data_ok, data_sram_rdata[31:0]  : load data return
//   MEM_to_WB_BUS[106:0], MEM_to_WB_valid <- WB_allowin
//   MEM_RF_BUS[37:0] : {dest, rfrom_mem, final_result}, live only when MEM_FWD_EN is defined
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic [75:0]  EX_to_MEM_BUS,
  input  logic         EX_to_MEM_valid,
  output logic         MEM_allowin,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic [106:0] MEM_to_WB_BUS,
  output logic         MEM_to_WB_valid,
  input  logic         WB_allowin,
  output logic [37:0]  MEM_RF_BUS
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic        mem_valid, mem_ready_go, accept, wait_ok;
  logic [75:0] bus_r;
  logic [31:0] buf_r, raw, mem_result;
  logic [31:0] pc, alu_result;
  logic        gr_we, rfrom_mem, mem_req;
  logic [4:0]  dest;
  logic [3:0]  load_op;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  assign {pc, gr_we, dest, alu_result, load_op, rfrom_mem, mem_req} = bus_r;
  assign wait_ok         = state == WAIT && data_sram_data_ok;
  assign mem_ready_go    = !mem_req || state == DONE || wait_ok;
  assign MEM_allowin     = !mem_valid || (mem_ready_go && WB_allowin);
  assign MEM_to_WB_valid = mem_valid && mem_ready_go;
  assign accept          = EX_to_MEM_valid && MEM_allowin;
  always_comb begin
    state_nxt = (state == WAIT && !data_sram_data_ok) ? WAIT :
                (state != IDLE && !WB_allowin)        ? DONE :
                (accept && EX_to_MEM_BUS[0])          ? WAIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      bus_r     <= '0;
      buf_r     <= '0;
    end else begin
      state <= state_nxt;
      if (MEM_allowin) mem_valid <= EX_to_MEM_valid;
      if (accept) bus_r <= EX_to_MEM_BUS;
      if (wait_ok) buf_r <= data_sram_rdata;
    end
  end
  // same-cycle data bypasses the buffer so a load leaves with zero extra latency
  assign raw    = wait_ok ? data_sram_rdata : buf_r;
  assign lane_b = raw[{alu_result[1:0], 3'b000} +: 8];
  assign lane_h = alu_result[1] ? raw[31:16] : raw[15:0];
  assign mem_result = load_op[1:0] == 2'b00 ? {{24{~load_op[2] & lane_b[7]}}, lane_b} :
                      load_op[1:0] == 2'b01 ? {{16{~load_op[2] & lane_h[15]}}, lane_h} : raw;
  assign MEM_to_WB_BUS = {pc, gr_we, dest, mem_result, alu_result, load_op, rfrom_mem};
`ifdef MEM_FWD_EN
  // rfrom_mem tells the decoder the value is a load result, so it stalls while data is pending
  logic [31:0] final_result;
  assign final_result = rfrom_mem ? mem_result : alu_result;
  assign MEM_RF_BUS   = {dest & {5{gr_we & mem_valid}}, rfrom_mem, final_result};
`else
  assign MEM_RF_BUS = 38'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage
module tb_mem_stage;
  logic         clk, resetn;
  logic [75:0]  EX_to_MEM_BUS;
  logic         EX_to_MEM_valid, MEM_allowin, data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [106:0] MEM_to_WB_BUS;
  logic         MEM_to_WB_valid, WB_allowin;
  logic [37:0]  MEM_RF_BUS;
  logic [31:0]  d_pc, d_alu;
  logic         d_we, d_rfrom, d_req;
  logic [4:0]   d_dest;
  logic [3:0]   d_lop;
  int checks = 0, errors = 0;
  typedef struct {
    logic [106:0] wb;
    logic         is_load, delivered, gr_we, rfrom;
    logic [31:0]  rdata, fin;
    logic [4:0]   dest;
  } item_t;
  item_t q[$];
  logic [31:0] last_rdata = 0;
  assign EX_to_MEM_BUS = {d_pc, d_we, d_dest, d_alu, d_lop, d_rfrom, d_req};
  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .EX_to_MEM_BUS(EX_to_MEM_BUS), .EX_to_MEM_valid(EX_to_MEM_valid), .MEM_allowin(MEM_allowin),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .MEM_to_WB_BUS(MEM_to_WB_BUS), .MEM_to_WB_valid(MEM_to_WB_valid), .WB_allowin(WB_allowin),
    .MEM_RF_BUS(MEM_RF_BUS)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(string name, logic [106:0] act, logic [106:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ext(logic [31:0] raw, int off, logic [3:0] op);
    logic [31:0] v;
    if (op[1:0] == 2'd0) begin
      v = (raw >> (8 * off)) & 32'hFF;
      if (!op[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (op[1:0] == 2'd1) begin
      v = (raw >> (16 * (off / 2))) & 32'hFFFF;
      if (!op[2] && v[15]) v = v | 32'hFFFF_0000;
    end else v = raw;
    return v;
  endfunction
  function automatic logic outstanding();
    return q.size() != 0 && q[0].is_load && !q[0].delivered;
  endfunction
  task automatic drive_rand();
    EX_to_MEM_valid = $urandom_range(0, 9) < 6;
    d_pc    = $urandom;
    d_alu   = $urandom;
    d_we    = 1'($urandom_range(0, 1));
    d_dest  = 5'($urandom_range(0, 31));
    d_lop   = 4'($urandom_range(0, 15));
    d_req   = 1'($urandom_range(0, 1));
    d_rfrom = d_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
    WB_allowin = $urandom_range(0, 9) < 7;
    data_sram_rdata = $urandom;
    if (outstanding()) begin
      data_sram_data_ok = $urandom_range(0, 2) == 0;
      if (data_sram_data_ok) data_sram_rdata = q[0].rdata;
    end else data_sram_data_ok = $urandom_range(0, 4) == 0;
  endtask
  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      last_rdata = 0;
    end else begin
      logic has, ok_now, ready;
      item_t t;
      has    = q.size() != 0;
      ok_now = outstanding() && data_sram_data_ok;
      ready  = has && (!q[0].is_load || q[0].delivered || ok_now);
      chk("allowin", 107'(MEM_allowin), 107'(!has || (ready && WB_allowin)));
      chk("wb_valid", 107'(MEM_to_WB_valid), 107'(ready));
`ifdef MEM_FWD_EN
      chk("rf_dest", 107'(MEM_RF_BUS[37:33]), 107'((has && q[0].gr_we) ? q[0].dest : 5'd0));
      if (has) chk("rf_rfrom", 107'(MEM_RF_BUS[32]), 107'(q[0].rfrom));
      if (ready) chk("rf_final", 107'(MEM_RF_BUS[31:0]), 107'(q[0].fin));
`else
      chk("rf_tied", 107'(MEM_RF_BUS), 107'(0));
`endif
      if (ready && WB_allowin) begin
        chk("wb_bus", MEM_to_WB_BUS, q[0].wb);
        void'(q.pop_front());
      end else if (ok_now) begin
        t = q[0];
        t.delivered = 1;
        q[0] = t;
      end
      if (EX_to_MEM_valid && (!has || (ready && WB_allowin))) begin
        logic [31:0] mr;
        t.is_load = d_req;
        t.delivered = 0;
        t.rdata = $urandom;
        if (d_req) last_rdata = t.rdata;
        mr = ext(last_rdata, int'(d_alu[1:0]), d_lop);
        t.gr_we = d_we;
        t.dest  = d_dest;
        t.rfrom = d_rfrom;
        t.fin   = d_rfrom ? mr : d_alu;
        t.wb    = {d_pc, d_we, d_dest, mr, d_alu, d_lop, d_rfrom};
        q.push_back(t);
      end
    end
  end
  initial begin
    logic found;
    resetn = 0;
    EX_to_MEM_valid = 0; data_sram_data_ok = 0; data_sram_rdata = 0; WB_allowin = 1;
    d_pc = 0; d_alu = 0; d_we = 0; d_dest = 0; d_lop = 0; d_rfrom = 0; d_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 107'(MEM_to_WB_valid), 107'(0));
    chk("rst_allowin", 107'(MEM_allowin), 107'(1));
    chk("rst_wb_bus", MEM_to_WB_BUS, 107'(0));
    chk("rst_rf_bus", 107'(MEM_RF_BUS), 107'(0));
    @(posedge clk);
    #1 resetn = 1;
    drive_rand();
    repeat (3000) begin
      @(posedge clk);
      #1 drive_rand();
    end
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (outstanding()) begin
        found = 1;
        resetn = 0;
        EX_to_MEM_valid = 0;
        data_sram_data_ok = 0;
      end else drive_rand();
    end
    chk("wait_reached", 107'(found), 107'(1));
    @(posedge clk);
    #1 resetn = 1;
    data_sram_data_ok = 1;
    data_sram_rdata = 32'hDEAD_BEEF;
    WB_allowin = 1;
    @(negedge clk);
    chk("stale_ok_valid", 107'(MEM_to_WB_valid), 107'(0));
    chk("stale_ok_bus", MEM_to_WB_BUS, 107'(0));
    @(posedge clk);
    #1 data_sram_data_ok = 0;
    @(negedge clk);
    chk("stale_buf_bus", MEM_to_WB_BUS, 107'(0));
    chk("stale_allowin", 107'(MEM_allowin), 107'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
